// File: rtl/matrix_ls_responder_if.sv
// -----------------------------------------------------------------------------
// matrix_ls_responder_if
// Groups the signals around the matrix load/store responder into one bundle:
//   request side : req_valid, req_ready, req_opcode, req_matrix, req_addr
//                  (+ req_stride when MLS_STRIDE_EN is defined)
//   memory side  : mem_ren, mem_wen, mem_addr, mem_wdata, mem_rdata, mem_ready
//   MRF side     : mrf_wen, mrf_sel, mrf_row, mrf_wdata, mrf_rdata
//   status       : mhit (transfer complete pulse), err (illegal opcode pulse)
// Modports:
//   slave  - the responder itself
//   master - the environment (requester, scratchpad, matrix register file)
// Optional feature macro: MLS_STRIDE_EN (adds req_stride).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface matrix_ls_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_opcode;
    logic [3:0]  req_matrix;
    logic [31:0] req_addr;
`ifdef MLS_STRIDE_EN
    logic [31:0] req_stride;
`endif
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        mrf_wen;
    logic [3:0]  mrf_sel;
    logic [1:0]  mrf_row;
    logic [63:0] mrf_wdata;
    logic [63:0] mrf_rdata;
    logic        mhit;
    logic        err;

    modport slave (
`ifdef MLS_STRIDE_EN
        input  req_stride,
`endif
        input  req_valid, req_opcode, req_matrix, req_addr,
        input  mem_rdata, mem_ready, mrf_rdata,
        output req_ready,
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        output mrf_wen, mrf_sel, mrf_row, mrf_wdata,
        output mhit, err
    );

    modport master (
`ifdef MLS_STRIDE_EN
        output req_stride,
`endif
        output req_valid, req_opcode, req_matrix, req_addr,
        output mem_rdata, mem_ready, mrf_rdata,
        input  req_ready,
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        input  mrf_wen, mrf_sel, mrf_row, mrf_wdata,
        input  mhit, err
    );
endinterface

// File: rtl/matrix_ls_responder.sv
// -----------------------------------------------------------------------------
// matrix_ls_responder
// Executes M_LOAD / M_STORE requests by moving the four 64-bit rows of one
// matrix register between the scratchpad and the matrix register file (MRF).
//   M_LOAD  (opcode 01): scratchpad row -> MRF row, one row per mem_ready.
//   M_STORE (opcode 10): MRF row -> scratchpad row, one row per mem_ready.
//   Other opcodes are rejected with a one-cycle err pulse.
// Ports:
//   CLK  - sole clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - matrix_ls_responder_if.slave (request, memory, MRF, status)
// Optional feature macro: MLS_STRIDE_EN
//   defined   : req_stride is latched per request, row address = base + row*stride
//   undefined : fixed row stride of 8 bytes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module matrix_ls_responder (
    input  logic                  CLK,
    input  logic                  nRST,
    matrix_ls_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    state_t      state_reg;
    logic [1:0]  row_reg;
    logic [3:0]  matrix_reg;
    logic [31:0] addr_reg;     // address of the current row, not the base
    logic        err_reg;
    logic [31:0] row_stride;
    logic        active;

`ifdef MLS_STRIDE_EN
    logic [31:0] stride_reg;
    assign row_stride = stride_reg;
`else
    assign row_stride = 32'd8;
`endif

    assign active = (state_reg == LOAD) || (state_reg == STORE);

    // The opcode is kept implicitly: the state (LOAD/STORE) records which
    // operation was accepted. addr_reg advances by the stride on every
    // completed row, so it always equals base + row*stride (mod 2^32).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg  <= IDLE;
            row_reg    <= 2'd0;
            matrix_reg <= 4'd0;
            addr_reg   <= 32'd0;
            err_reg    <= 1'b0;
`ifdef MLS_STRIDE_EN
            stride_reg <= 32'd0;
`endif
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        matrix_reg <= bus.req_matrix;
                        addr_reg   <= bus.req_addr;
                        row_reg    <= 2'd0;
`ifdef MLS_STRIDE_EN
                        stride_reg <= bus.req_stride;
`endif
                        case (bus.req_opcode)
                            OP_LOAD:  state_reg <= LOAD;
                            OP_STORE: state_reg <= STORE;
                            default:  err_reg   <= 1'b1;
                        endcase
                    end
                end
                LOAD, STORE: begin
                    if (bus.mem_ready) begin
                        row_reg  <= row_reg + 2'd1;
                        addr_reg <= addr_reg + row_stride;
                        if (row_reg == 2'd3) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register. Address, select and
    // data outputs are forced to zero outside an active transfer so that an
    // asynchronous reset clears them immediately.
    assign bus.req_ready = (state_reg == IDLE);
    assign bus.mem_ren   = (state_reg == LOAD);
    assign bus.mem_wen   = (state_reg == STORE);
    assign bus.mem_addr  = active ? addr_reg : 32'd0;
    assign bus.mem_wdata = (state_reg == STORE) ? bus.mrf_rdata : 64'd0;
    assign bus.mrf_sel   = active ? matrix_reg : 4'd0;
    assign bus.mrf_row   = active ? row_reg : 2'd0;
    // The MRF write happens in the same cycle the scratchpad returns data.
    assign bus.mrf_wen   = (state_reg == LOAD) && bus.mem_ready;
    assign bus.mrf_wdata = (state_reg == LOAD) ? bus.mem_rdata : 64'd0;
    assign bus.mhit      = (state_reg == DONE);
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_matrix_ls_responder.sv
`timescale 1ns/1ps
module tb_matrix_ls_responder;
    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] FIXED_STRIDE = 32'd8;

    // next request presented early (during DONE) by test_back_to_back
    logic [1:0]  nx_op;
    logic [3:0]  nx_mat;
    logic [31:0] nx_addr;
    logic [31:0] nx_stride;

    matrix_ls_responder_if bus();

    matrix_ls_responder dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    // scratchpad contents as a pure function of the address
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hC0DE_0000, ~a + 32'h1357_9BDF};
    endfunction

    // MRF contents as a pure function of (matrix, row)
    function automatic logic [63:0] mrf_word(input logic [3:0] s, input logic [1:0] r);
        return {16'hBEEF ^ {10'd0, s, r}, 16'(s) * 16'h1111, 16'(r) * 16'h0F0F, 16'hCAFE};
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);
    assign bus.mrf_rdata = mrf_word(bus.mrf_sel, bus.mrf_row);

    // One whole transfer checked cycle by cycle against the rules:
    // row r lives at addr + r*stride, advances only on mem_ready, and mhit
    // follows in the cycle after the fourth completed row.
    task automatic do_transfer(input logic [1:0] op, input logic [3:0] mat,
                               input logic [31:0] addr, input logic [31:0] stride,
                               input int min_w, input int max_w, input int exp_lat,
                               input bit preset, input bit present_next, input string name);
        int cyc, rows, wait_left;
        bit done;
        logic [31:0] exp_addr;
        cyc = 0; rows = 0; done = 0;
        wait_left = $urandom_range(max_w, min_w);
        @(negedge CLK);
        bus.mem_ready = 1'b0;
        if (!preset) begin
            bus.req_valid  = 1'b1;
            bus.req_opcode = op;
            bus.req_matrix = mat;
            bus.req_addr   = addr;
`ifdef MLS_STRIDE_EN
            bus.req_stride = stride;
`endif
        end
        #1;
        n_cmp++;
        if ({bus.req_ready, bus.mhit} !== 2'b10) begin
            n_bad++;
            $display("FAIL %s idle_ready_mhit: got %b want 10", name, {bus.req_ready, bus.mhit});
        end
        @(posedge CLK);
        while (!done && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            bus.req_valid = 1'b0;
            exp_addr = addr + 32'(rows) * stride;
            if (rows < 4) begin
                if (wait_left > 0) begin
                    bus.mem_ready = 1'b0;
                    wait_left--;
                end else begin
                    bus.mem_ready = 1'b1;
                end
            end else begin
                bus.mem_ready = 1'($urandom);
                if (present_next) begin
                    bus.req_valid  = 1'b1;
                    bus.req_opcode = nx_op;
                    bus.req_matrix = nx_mat;
                    bus.req_addr   = nx_addr;
`ifdef MLS_STRIDE_EN
                    bus.req_stride = nx_stride;
`endif
                end
            end
            #1;
            if (rows < 4) begin
                n_cmp++;
                if ({bus.mem_ren, bus.mem_wen} !== ((op == 2'b01) ? 2'b10 : 2'b01)) begin
                    n_bad++;
                    $display("FAIL %s row%0d strobes: got %b want %b", name, rows,
                             {bus.mem_ren, bus.mem_wen}, (op == 2'b01) ? 2'b10 : 2'b01);
                end
                n_cmp++;
                if (bus.mem_addr !== exp_addr) begin
                    n_bad++;
                    $display("FAIL %s row%0d mem_addr: got %h want %h", name, rows, bus.mem_addr, exp_addr);
                end
                n_cmp++;
                if ({bus.req_ready, bus.mhit} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL %s row%0d busy_ready_mhit: got %b want 00", name, rows, {bus.req_ready, bus.mhit});
                end
                n_cmp++;
                if ({bus.mrf_sel, bus.mrf_row} !== {mat, 2'(rows)}) begin
                    n_bad++;
                    $display("FAIL %s row%0d mrf_sel_row: got %h want %h", name, rows,
                             {bus.mrf_sel, bus.mrf_row}, {mat, 2'(rows)});
                end
                if (op == 2'b01) begin
                    n_cmp++;
                    if (bus.mrf_wen !== bus.mem_ready) begin
                        n_bad++;
                        $display("FAIL %s row%0d mrf_wen: got %b want %b", name, rows, bus.mrf_wen, bus.mem_ready);
                    end
                    if (bus.mem_ready) begin
                        n_cmp++;
                        if (bus.mrf_wdata !== mem_word(exp_addr)) begin
                            n_bad++;
                            $display("FAIL %s row%0d mrf_wdata: got %h want %h", name, rows,
                                     bus.mrf_wdata, mem_word(exp_addr));
                        end
                    end
                end else begin
                    n_cmp++;
                    if (bus.mrf_wen !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s row%0d store_mrf_wen: got %b want 0", name, rows, bus.mrf_wen);
                    end
                    n_cmp++;
                    if (bus.mem_wdata !== mrf_word(mat, 2'(rows))) begin
                        n_bad++;
                        $display("FAIL %s row%0d mem_wdata: got %h want %h", name, rows,
                                 bus.mem_wdata, mrf_word(mat, 2'(rows)));
                    end
                end
                if (bus.mem_ready) begin
                    rows++;
                    wait_left = $urandom_range(max_w, min_w);
                end
            end else begin
                n_cmp++;
                if (bus.mhit !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s mhit: got %b want 1 at cycle %0d", name, bus.mhit, cyc);
                end
                n_cmp++;
                if ({bus.mem_ren, bus.mem_wen, bus.mrf_wen, bus.req_ready} !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL %s done_outputs: got %b want 0000", name,
                             {bus.mem_ren, bus.mem_wen, bus.mrf_wen, bus.req_ready});
                end
                if (exp_lat > 0) begin
                    n_cmp++;
                    if (cyc != exp_lat) begin
                        n_bad++;
                        $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
                    end
                end
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got no mhit want mhit within 400 cycles", name);
        end
        $display("%s: op=%b mat=%0d addr=%h stride=%h mhit_cycle=%0d", name, op, mat, addr, stride, cyc);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_opcode = 2'b00; bus.req_matrix = 4'd0;
        bus.req_addr = 32'd0; bus.mem_ready = 1'b1;
`ifdef MLS_STRIDE_EN
        bus.req_stride = 32'd0;
`endif
        nRST = 1'b0;
        #2;
        n_cmp++;
        if ({bus.mem_ren, bus.mem_wen, bus.mrf_wen, bus.mhit, bus.err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {bus.mem_ren, bus.mem_wen, bus.mrf_wen, bus.mhit, bus.err});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mrf_sel, bus.mrf_row} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_addr: got %h want 0", {bus.mem_addr, bus.mrf_sel, bus.mrf_row});
        end
        n_cmp++;
        if ({bus.mem_wdata, bus.mrf_wdata} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {bus.mem_wdata, bus.mrf_wdata});
        end
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
        end
        $display("reset: checked outputs during and after reset");
    endtask

    task automatic test_load();
        do_transfer(2'b01, 4'd3, 32'h100, FIXED_STRIDE, 0, 0, 5, 0, 0, "load_m3");
    endtask

    task automatic test_store();
        do_transfer(2'b10, 4'd7, 32'h40, FIXED_STRIDE, 2, 2, 13, 0, 0, "store_m7");
    endtask

    task automatic test_illegal(input logic [1:0] op);
        @(negedge CLK);
        bus.mem_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_matrix = 4'($urandom);
        bus.req_addr   = $urandom;
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.err, bus.req_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL illegal_%b err_ready: got %b want 11", op, {bus.err, bus.req_ready});
        end
        n_cmp++;
        if ({bus.mem_ren, bus.mem_wen, bus.mrf_wen, bus.mhit} !== 4'b0000) begin
            n_bad++;
            $display("FAIL illegal_%b strobes: got %b want 0000", op,
                     {bus.mem_ren, bus.mem_wen, bus.mrf_wen, bus.mhit});
        end
        @(negedge CLK);
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++;
        if ({bus.err, bus.req_ready, bus.mem_ren, bus.mem_wen} !== 4'b0100) begin
            n_bad++;
            $display("FAIL illegal_%b after_pulse: got %b want 0100", op,
                     {bus.err, bus.req_ready, bus.mem_ren, bus.mem_wen});
        end
        $display("illegal: op=%b rejected", op);
    endtask

    task automatic test_wrap();
        do_transfer(2'b01, 4'd9, 32'hFFFF_FFF8, FIXED_STRIDE, 0, 0, 5, 0, 0, "load_wrap");
    endtask

    task automatic test_reset_mid();
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FF00;
        @(negedge CLK);
        bus.mem_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_opcode = 2'b01;
        bus.req_matrix = 4'd5;
        bus.req_addr   = base;
`ifdef MLS_STRIDE_EN
        bus.req_stride = FIXED_STRIDE;
`endif
        @(posedge CLK);
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            bus.req_valid = 1'b0;
            bus.mem_ready = 1'b1;
        end
        #1;
        n_cmp++;
        if ({bus.mem_addr, bus.mrf_row} !== {base + 32'd16, 2'd2}) begin
            n_bad++;
            $display("FAIL rst_mid row2: got %h want %h", {bus.mem_addr, bus.mrf_row}, {base + 32'd16, 2'd2});
        end
        #1;
        nRST = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_ren, bus.mem_wen, bus.mrf_wen, bus.mhit, bus.err} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_mid strobes: got %b want 00000",
                     {bus.mem_ren, bus.mem_wen, bus.mrf_wen, bus.mhit, bus.err});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mrf_sel, bus.mrf_row, bus.mrf_wdata} !== 102'd0) begin
            n_bad++;
            $display("FAIL rst_mid addr_data: got %h want 0",
                     {bus.mem_addr, bus.mrf_sel, bus.mrf_row, bus.mrf_wdata});
        end
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        bus.mem_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if ({bus.req_ready, bus.mhit, bus.mem_ren} !== 3'b100) begin
                n_bad++;
                $display("FAIL rst_mid after_release c%0d: got %b want 100", c,
                         {bus.req_ready, bus.mhit, bus.mem_ren});
            end
            @(negedge CLK);
        end
        $display("reset_mid: load abandoned at row 2 base=%h", base);
    endtask

    task automatic test_back_to_back();
        nx_op     = 2'b10;
        nx_mat    = 4'd12;
        nx_addr   = 32'h0000_2000;
        nx_stride = FIXED_STRIDE;
        do_transfer(2'b01, 4'd1, 32'h0000_1000, FIXED_STRIDE, 0, 1, 0, 0, 1, "b2b_first");
        do_transfer(nx_op, nx_mat, nx_addr, nx_stride, 0, 1, 0, 1, 0, "b2b_second");
    endtask

`ifdef MLS_STRIDE_EN
    task automatic test_stride();
        do_transfer(2'b01, 4'd2, 32'h0, 32'h20, 0, 0, 5, 0, 0, "stride_load");
        do_transfer(2'b10, 4'd6, $urandom, $urandom, 0, 2, 0, 0, 0, "stride_store_rand");
    endtask
`endif

    task automatic test_random();
        int r;
        logic [31:0] stride;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(9, 0);
`ifdef MLS_STRIDE_EN
            stride = $urandom;
`else
            stride = FIXED_STRIDE;
`endif
            if (r == 0) begin
                test_illegal(($urandom % 2) ? 2'b11 : 2'b00);
            end else begin
                do_transfer((r % 2) ? 2'b01 : 2'b10, 4'($urandom), $urandom, stride,
                            0, 3, 0, 0, 0, "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_illegal(2'b11);
        test_illegal(2'b00);
        test_wrap();
        test_reset_mid();
        test_back_to_back();
`ifdef MLS_STRIDE_EN
        test_stride();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
